// File: rtl/matrix_scan_pkg.sv
// matrix_scan_pkg: shared constants for the matrix scan sequencer.
//   ROW_* : row codes driven on ch1..ch3 (0 = no row selected)
//   DIGIT_MAX : largest decimal digit accepted on a load
//   TOF_TABLE : two-out-of-five column code per digit, {w7,w4,w2,w1,w0}
package matrix_scan_pkg;

   localparam logic [2:0] ROW_NONE  = 3'd0;
   localparam logic [2:0] ROW_FIRST = 3'd1;
   localparam logic [2:0] ROW_LAST  = 3'd7;

   localparam logic [3:0] DIGIT_MAX = 4'd9;

   // Entry n is the code for digit n; 0 uses weights 7+4.
   localparam logic [9:0][4:0] TOF_TABLE = {
      5'b10100,  // 9
      5'b10010,  // 8
      5'b10001,  // 7
      5'b01100,  // 6
      5'b01010,  // 5
      5'b01001,  // 4
      5'b00110,  // 3
      5'b00101,  // 2
      5'b00011,  // 1
      5'b11000   // 0
   };

endpackage

// File: rtl/matrix_scan_tof_encode.sv
// tof_encode: combinational decimal digit -> two-out-of-five code.
//   digit : input digit (0..15 presented, 0..9 meaningful)
//   code  : column pattern {w7,w4,w2,w1,w0}, all zero for invalid digits
//   valid : digit is in 0..9
module tof_encode
   import matrix_scan_pkg::*;
(
   input  logic [3:0] digit,
   output logic [4:0] code,
   output logic       valid
);

   always_comb begin
      valid = (digit <= DIGIT_MAX);
      code  = valid ? TOF_TABLE[digit] : 5'b00000;
   end

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan: row scan sequencer for a 7-row two-out-of-five matrix display.
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : scan enable (low = idle, all outputs dark)
//   load, digit_in  : one-cycle strobe capturing a digit into the shadow register
//   ch1..ch3        : row code 1..7 (000 = no row)
//   v               : display gate, low in the first dwell cycle of each row
//   col             : 2-of-5 code of the displayed digit
//   frame_done      : pulse in the last cycle of row 7
//   err             : sticky flag, last load carried a digit above 9
//   duty            : brightness, only when MATRIX_SCAN_DIM_EN is defined
// The displayed digit is swapped only at the frame boundary so a frame never
// shows two different digits.
module matrix_scan
   import matrix_scan_pkg::*;
#(
   parameter int DWELL   = 1000,
   parameter int DWELL_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] digit_in,
`ifdef MATRIX_SCAN_DIM_EN
   input  logic [3:0] duty,
`endif
   output logic       ch1,
   output logic       ch2,
   output logic       ch3,
   output logic       v,
   output logic [4:0] col,
   output logic       frame_done,
   output logic       err
);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

   logic [2:0]         row_q, row_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [3:0]         shadow_q, shadow_d, active_q, active_d;
   logic [4:0]         col_q, col_d;
   logic               v_q, v_d, frame_done_q, frame_done_d, err_q, err_d;
   logic               last_dwell, boundary, in_valid, act_valid;
   logic [4:0]         in_code, act_code;

   tof_encode u_enc_in  (.digit(digit_in), .code(in_code),  .valid(in_valid));
   tof_encode u_enc_act (.digit(active_d), .code(act_code), .valid(act_valid));

`ifdef MATRIX_SCAN_DIM_EN
   localparam int LW = DWELL_W + 5;
   localparam int STEP = (DWELL - 1) / 16;
   logic [LW-1:0] on_limit;
   assign on_limit = LW'(1) + LW'(duty) * LW'(STEP);
`endif

   always_comb begin
      last_dwell = (dwell_q == DWELL_LAST);
      boundary   = (row_q == ROW_LAST) && last_dwell;

      // A valid load landing on the boundary goes straight to the display.
      active_d = active_q;
      if (boundary)
         active_d = (load && in_valid) ? digit_in : shadow_q;

      shadow_d = shadow_q;
      err_d    = err_q;
      if (load) begin
         if (in_valid) begin
            shadow_d = digit_in;
            err_d    = 1'b0;
         end else begin
            err_d    = 1'b1;
         end
      end

      row_d   = row_q;
      dwell_d = dwell_q + DWELL_W'(1);
      if (!en) begin
         row_d   = ROW_NONE;
         dwell_d = '0;
      end else if (row_q == ROW_NONE) begin
         row_d   = ROW_FIRST;
         dwell_d = '0;
      end else if (last_dwell) begin
         row_d   = (row_q == ROW_LAST) ? ROW_FIRST : row_q + 3'd1;
         dwell_d = '0;
      end

      // Outputs are computed from next state so they register alongside it.
      col_d = (row_d != ROW_NONE && act_valid) ? act_code : 5'b00000;
      v_d   = (row_d != ROW_NONE) && (dwell_d != '0);
`ifdef MATRIX_SCAN_DIM_EN
      v_d   = v_d && ({5'b00000, dwell_d} < on_limit);
`endif
      frame_done_d = (row_d == ROW_LAST) && (dwell_d == DWELL_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q        <= ROW_NONE;
         dwell_q      <= '0;
         shadow_q     <= 4'd0;
         active_q     <= 4'd0;
         col_q        <= 5'b00000;
         v_q          <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         row_q        <= row_d;
         dwell_q      <= dwell_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         col_q        <= col_d;
         v_q          <= v_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign {ch1, ch2, ch3} = row_q;
   assign v          = v_q;
   assign col        = col_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule
